// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: the operation enum and
// the priority encoder that reduces the control inputs to one operation.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_REL  = 3'd2,
        OP_LD   = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    // ret > call > ld_pc > rel_br > inc_pc; reset is handled by the registers.
    function automatic op_e prio_encode(
        input logic ret,
        input logic call,
        input logic ld_pc,
        input logic rel_br,
        input logic inc_pc
    );
        op_e op_v;
        if (ret) begin
            op_v = OP_RET;
        end else if (call) begin
            op_v = OP_CALL;
        end else if (ld_pc) begin
            op_v = OP_LD;
        end else if (rel_br) begin
            op_v = OP_REL;
        end else if (inc_pc) begin
            op_v = OP_INC;
        end else begin
            op_v = OP_NONE;
        end
        return op_v;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO. Only the occupancy counter is reset; entry storage
// is never read while the stack is empty, so it carries no reset.
module return_stack #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    import pc_seq_pkg::*;

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  top_cnt_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == CNT_W'(STACK_DEPTH));
    assign empty     = (count_r == '0);
    assign top_cnt_s = count_r - CNT_W'(1);
    assign wr_idx_s  = IDX_W'(count_r);
    assign top_idx_s = IDX_W'(top_cnt_s);
    // Pop wins over push so the counter can never move two ways at once.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && !full && !do_pop_s;

    // Top-of-stack read; forced to zero when nothing valid is stored.
    always_comb begin
        dout = '0;
        if (empty) begin
            dout = '0;
        end else begin
            dout = mem_r[top_idx_s];
        end
    end

    // Occupancy counter, bounded to 0..STACK_DEPTH by the guards above.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (do_pop_s) begin
            count_r <= count_r - CNT_W'(1);
        end else if (do_push_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, relative branch, absolute jump,
// call/return through a bounded return stack, with a sticky stack error flag.
module pc_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              rel_br,
    input  logic              call,
    input  logic              ret,
    input  logic              clr_err,
    input  logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);
    import pc_seq_pkg::*;

    op_e               op_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] ret_addr_s;
    logic [ADDR_W-1:0] top_s;
    logic              push_s;
    logic              pop_s;
    logic              err_set_s;
    logic              full_s;
    logic              empty_s;
    logic              stack_err_r;

    assign op_s        = prio_encode(ret, call, ld_pc, rel_br, inc_pc);
    assign ret_addr_s  = pc_r + ADDR_W'(1);
    assign pc_addr     = pc_r;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = stack_err_r;

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .dout  (top_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-PC mux plus stack handshakes; a rejected call/ret only flags an error.
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        case (op_s)
            OP_INC:  pc_next_s = pc_r + ADDR_W'(1);
            // Offset is already ADDR_W wide, so the modular add is the sign-extended add.
            OP_REL:  pc_next_s = pc_r + ir_addr;
            OP_LD:   pc_next_s = ir_addr;
            OP_CALL: begin
                if (!full_s) begin
                    push_s    = 1'b1;
                    pc_next_s = ir_addr;
                end else begin
                    err_set_s = 1'b1;
                end
            end
            OP_RET: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    pc_next_s = top_s;
                end else begin
                    err_set_s = 1'b1;
                end
            end
            OP_NONE: pc_next_s = pc_r;
            default: pc_next_s = pc_r;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= ADDR_W'(RESET_ADDR);
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Sticky error flag; a new error in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err_r <= 1'b0;
        end else if (err_set_s) begin
            stack_err_r <= 1'b1;
        end else if (clr_err) begin
            stack_err_r <= 1'b0;
        end else begin
            stack_err_r <= stack_err_r;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pc_sequencer;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b1000000;
    localparam logic [6:0] C_RET  = 7'b0100000;
    localparam logic [6:0] C_CALL = 7'b0010000;
    localparam logic [6:0] C_LD   = 7'b0001000;
    localparam logic [6:0] C_REL  = 7'b0000100;
    localparam logic [6:0] C_INC  = 7'b0000010;
    localparam logic [6:0] C_CLR  = 7'b0000001;

    typedef struct {
        string      name;
        logic [4:0] pc;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld_pc = 1'b0;
    logic       inc_pc = 1'b0;
    logic       rel_br = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       clr_err = 1'b0;
    logic [4:0] ir_addr = 5'd0;
    logic [4:0] pc_addr;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer #(
        .ADDR_W      (5),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_pc       (ld_pc),
        .inc_pc      (inc_pc),
        .rel_br      (rel_br),
        .call        (call),
        .ret         (ret),
        .clr_err     (clr_err),
        .ir_addr     (ir_addr),
        .pc_addr     (pc_addr),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of controls and queue the state expected after the edge.
    task automatic step(input string name, input logic [6:0] ctl, input logic [4:0] ir,
                        input logic [4:0] xpc, input logic xfull, input logic xempty,
                        input logic xerr);
        exp_t x;
        {rst, ret, call, ld_pc, rel_br, inc_pc, clr_err} = ctl;
        ir_addr = ir;
        @(posedge clk);
        x.name = name; x.pc = xpc; x.full = xfull; x.empty = xempty; x.err = xerr;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: outputs are registered, so the negedge after the edge is stable.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            vectors++;
            if (pc_addr !== e.pc || stack_full !== e.full ||
                stack_empty !== e.empty || stack_err !== e.err) begin
                miscompares++;
                $display("FAIL %s: got pc=%0d full=%b empty=%b err=%b, want pc=%0d full=%b empty=%b err=%b",
                         e.name, pc_addr, stack_full, stack_empty, stack_err,
                         e.pc, e.full, e.empty, e.err);
            end
        end
    end

    initial begin
        @(negedge clk);
        step("reset", C_RST, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            step("inc_wrap", C_INC, 5'd0, 5'(i % 32), 1'b0, 1'b1, 1'b0);
        end
        step("hold_idle", C_NONE, 5'd17, 5'd1, 1'b0, 1'b1, 1'b0);

        step("ld_10",      C_LD,  5'd10,     5'd10, 1'b0, 1'b1, 1'b0);
        step("rel_neg3",   C_REL, 5'b11101,  5'd7,  1'b0, 1'b1, 1'b0);
        step("ld_30",      C_LD,  5'd30,     5'd30, 1'b0, 1'b1, 1'b0);
        step("rel_wrap",   C_REL, 5'd3,      5'd1,  1'b0, 1'b1, 1'b0);

        step("ld_4",       C_LD,   5'd4,  5'd4,  1'b0, 1'b1, 1'b0);
        step("call_20",    C_CALL, 5'd20, 5'd20, 1'b0, 1'b0, 1'b0);
        step("call_8",     C_CALL, 5'd8,  5'd8,  1'b0, 1'b0, 1'b0);
        step("ret_21",     C_RET,  5'd0,  5'd21, 1'b0, 1'b0, 1'b0);
        step("ret_5",      C_RET,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0);

        step("ld_0",       C_LD,   5'd0,  5'd0,  1'b0, 1'b1, 1'b0);
        step("fill_c1",    C_CALL, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0);
        step("fill_c2",    C_CALL, 5'd20, 5'd20, 1'b0, 1'b0, 1'b0);
        step("fill_c3",    C_CALL, 5'd6,  5'd6,  1'b0, 1'b0, 1'b0);
        step("fill_c4",    C_CALL, 5'd15, 5'd15, 1'b1, 1'b0, 1'b0);
        step("overflow",   C_CALL, 5'd9,  5'd15, 1'b1, 1'b0, 1'b1);
        step("ret_4th",    C_RET,  5'd0,  5'd7,  1'b0, 1'b0, 1'b1);
        step("ret_3rd",    C_RET,  5'd0,  5'd21, 1'b0, 1'b0, 1'b1);
        step("ret_2nd",    C_RET,  5'd0,  5'd11, 1'b0, 1'b0, 1'b1);
        step("ret_1st",    C_RET,  5'd0,  5'd1,  1'b0, 1'b1, 1'b1);

        step("clr_err",    C_CLR,         5'd0, 5'd1, 1'b0, 1'b1, 1'b0);
        step("underflow",  C_RET,         5'd0, 5'd1, 1'b0, 1'b1, 1'b1);
        step("clr_err2",   C_CLR,         5'd0, 5'd1, 1'b0, 1'b1, 1'b0);
        step("ret_and_clr", C_RET | C_CLR, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1);
        step("err_sticky", C_NONE,        5'd0, 5'd1, 1'b0, 1'b1, 1'b1);
        step("clr_err3",   C_CLR,         5'd0, 5'd1, 1'b0, 1'b1, 1'b0);

        step("ld_3",       C_LD, 5'd3, 5'd3, 1'b0, 1'b1, 1'b0);
        step("ld_inc_call", C_LD | C_INC | C_CALL, 5'd12, 5'd12, 1'b0, 1'b0, 1'b0);
        step("ret_4",      C_RET,  5'd0, 5'd4, 1'b0, 1'b1, 1'b0);
        step("call_7",     C_CALL, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
        step("rst_call",   C_RST | C_CALL, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
        step("ret_after_rst", C_RET, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("call_20b",   C_CALL, 5'd20, 5'd20, 1'b0, 1'b0, 1'b1);
        step("ret_over_call", C_RET | C_CALL, 5'd9, 5'd1, 1'b0, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
